// File: rtl/mhsa_mem_pkg.sv
// Shared memory map and reader state type for the MHSA memory model and its initiators.
package mhsa_mem_pkg;

  localparam int WEIGHT_BASE = 0;
  localparam int WEIGHT_SIZE = 2048;
  localparam int INPUT_BASE  = 2048;
  localparam int INPUT_SIZE  = 512;
  localparam int MEM_WIDTH   = 64;
  localparam int MEM_LENGTH  = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; storage is unreset, only pointers and count clear.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/mem_x_reader.sv
// Streams a contiguous word region out of the 1-cycle-read memory model through a
// credit-controlled FIFO, tagging each word with its row index and a last flag.
module mem_x_reader
  import mhsa_mem_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int ADDR_W        = 32,
  parameter int BASE_ADDR     = 2048,
  parameter int NUM_WORDS     = 512,
  parameter int WORDS_PER_ROW = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int ROW_W         = $clog2(NUM_WORDS / WORDS_PER_ROW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_last
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam int FW    = WIDTH + ROW_W + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] NUM_C    = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  rd_state_t        state;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             rd_pend;
  logic             issue;
  logic             push;
  logic             hs;

  logic [FW-1:0]    push_data;
  logic [FW-1:0]    pop_data;
  logic [AW:0]      fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  logic             head_last;
  logic [ROW_W-1:0] head_row;
  logic [WIDTH-1:0] head_data;

  // Credit counts the in-flight read but not a same-cycle pop, so a push never overflows.
  assign issue = (state == RUN) && (issue_cnt < NUM_C) &&
                 (({1'b0, fifo_count} + (AW+2)'(rd_pend)) < (AW+2)'(FIFO_DEPTH));

  assign push      = rd_pend && !fifo_full;
  assign push_data = {(recv_cnt == LAST_IDX),
                      ROW_W'(recv_cnt / CNT_W'(WORDS_PER_ROW)),
                      mem_rdata};

  sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (hs),
    .pop_data  (pop_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_last, head_row, head_data} = pop_data;

  assign out_valid    = !fifo_empty;
  assign hs           = out_valid && out_ready;
  assign out_data     = out_valid ? head_data : '0;
  assign out_row      = out_valid ? head_row  : '0;
  assign out_last     = out_valid && head_last;
  assign mem_write_en = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      out_cnt   <= '0;
      rd_pend   <= 1'b0;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= issue;
      // mem_addr always holds BASE_ADDR + issue_cnt, so the issued address is already on the bus.
      if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
        mem_addr  <= mem_addr + 1'b1;
      end
      if (rd_pend) recv_cnt <= recv_cnt + 1'b1;
      if (hs)      out_cnt  <= out_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          state     <= RUN;
          busy      <= 1'b1;
          issue_cnt <= '0;
          recv_cnt  <= '0;
          out_cnt   <= '0;
          mem_addr  <= ADDR_W'(BASE_ADDR);
        end
        RUN: if (hs && out_cnt == LAST_IDX) state <= DONE;
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_x_reader.sv
// Bench for mem_x_reader: three configurations share clock and reset; a word-k-equals-k
// memory model feeds each, and the expected stream is derived from index arithmetic.
module tb_mem_x_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        ready;
  int          sel;

  logic        start_a [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic        valid_a [3];
  logic        last_a  [3];
  logic        we_a    [3];
  logic [31:0] addr_a  [3];
  logic [63:0] rdata_a [3];
  logic [63:0] data_a  [3];
  logic [6:0]  row0;
  logic [0:0]  row1;
  logic [6:0]  row2;
  logic [63:0] o_row;

  int checks   = 0;
  int failures = 0;
  int idx;
  int donecnt;

  int base_t [3] = '{2048, 2048, 0};
  int num_t  [3] = '{512, 8, 2048};
  int wpr_t  [3] = '{4, 4, 16};

  always_comb begin
    for (int i = 0; i < 3; i++) start_a[i] = start && (sel == i);
    case (sel)
      0:       o_row = 64'(row0);
      1:       o_row = 64'(row1);
      default: o_row = 64'(row2);
    endcase
  end

  // Memory model: registered read, word k holds value k.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (!we_a[i]) rdata_a[i] <= {32'h0, addr_a[i]};
  end

  mem_x_reader u0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .mem_write_en(we_a[0]), .mem_addr(addr_a[0]), .mem_rdata(rdata_a[0]),
    .out_valid(valid_a[0]), .out_ready(ready), .out_data(data_a[0]),
    .out_row(row0), .out_last(last_a[0])
  );

  mem_x_reader #(.NUM_WORDS(8), .WORDS_PER_ROW(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .mem_write_en(we_a[1]), .mem_addr(addr_a[1]), .mem_rdata(rdata_a[1]),
    .out_valid(valid_a[1]), .out_ready(ready), .out_data(data_a[1]),
    .out_row(row1), .out_last(last_a[1])
  );

  mem_x_reader #(.BASE_ADDR(0), .NUM_WORDS(2048), .WORDS_PER_ROW(16)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .busy(busy_a[2]), .done(done_a[2]),
    .mem_write_en(we_a[2]), .mem_addr(addr_a[2]), .mem_rdata(rdata_a[2]),
    .out_valid(valid_a[2]), .out_ready(ready), .out_data(data_a[2]),
    .out_row(row2), .out_last(last_a[2])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then follows the transfer cycle by cycle. Cycle c is sampled on the
  // falling edge after rising edge c, where edge 0 is the one that samples start.
  task automatic run(input int budget, input bit full, input bit rnd,
                     input int stop_at, input int restart_at);
    int n        = num_t[sel];
    int base     = base_t[sel];
    int first_v  = -1;
    int gaps     = 0;
    int done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (full && c <= n + 3)
        chk("mem_addr", addr_a[sel], 64'(base + ((c < n) ? c : n)));
      if (valid_a[sel] && first_v < 0) first_v = c;
      if (full && first_v >= 0 && idx < n && !valid_a[sel]) gaps++;
      ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (valid_a[sel] && ready) begin
        chk("out_data", data_a[sel], 64'(base + idx));
        chk("out_row",  o_row,       64'(idx / wpr_t[sel]));
        chk("out_last", 64'(last_a[sel]), 64'(idx == n - 1));
        idx++;
      end
      if (done_a[sel]) begin
        donecnt++;
        done_cyc = c;
        chk("done_words", 64'(idx), 64'(n));
      end
      if (stop_at >= 0 && idx == stop_at) return;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    chk("done_seen", 64'(done_cyc >= 0), 64'd1);
    chk("done_count", 64'(donecnt), 64'd1);
    chk("busy_after", 64'(busy_a[sel]), 64'd0);
    if (full) begin
      chk("first_valid_cyc", 64'(first_v), 64'd2);
      chk("done_cyc", 64'(done_cyc), 64'(n + 3));
      chk("gaps", 64'(gaps), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    sel   = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(busy_a[0]),  64'd0);
    chk("rst_done",  64'(done_a[0]),  64'd0);
    chk("rst_valid", 64'(valid_a[0]), 64'd0);
    chk("rst_last",  64'(last_a[0]),  64'd0);
    chk("rst_row",   o_row,           64'd0);
    chk("rst_data",  data_a[0],       64'd0);
    chk("rst_addr",  64'(addr_a[0]),  64'd2048);
    chk("rst_we",    64'(we_a[0]),    64'd0);
    chk("rst_addr_w", 64'(addr_a[2]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-rate default transfer.
    idx = 0; donecnt = 0;
    run(600, 1'b1, 1'b0, -1, -1);

    // Downstream stalled from the start: credit caps reads at the FIFO depth.
    idx = 0; donecnt = 0;
    ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("stall_addr",  64'(addr_a[0]),  64'd2052);
    chk("stall_valid", 64'(valid_a[0]), 64'd1);
    chk("stall_data",  data_a[0],       64'd2048);
    repeat (3) @(negedge clk);
    chk("stall_hold_data", data_a[0],      64'd2048);
    chk("stall_hold_addr", 64'(addr_a[0]), 64'd2052);
    chk("stall_hold_row",  o_row,          64'd0);
    // run() starts by pulsing start; busy means that pulse is ignored.
    run(700, 1'b0, 1'b0, -1, -1);
    chk("stall_total", 64'(idx), 64'd512);

    // Small region with random backpressure.
    sel = 1;
    for (int rep = 0; rep < 3; rep++) begin
      idx = 0; donecnt = 0;
      run(200, 1'b0, 1'b1, -1, -1);
      chk("rnd_total", 64'(idx), 64'd8);
    end

    // Second start while busy is ignored.
    idx = 0; donecnt = 0;
    run(100, 1'b0, 1'b0, -1, 3);
    chk("restart_total", 64'(idx), 64'd8);
    repeat (4) @(negedge clk);
    chk("restart_idle_busy",  64'(busy_a[1]),  64'd0);
    chk("restart_idle_valid", 64'(valid_a[1]), 64'd0);

    // Reset after ten accepted words, then a fresh transfer from BASE_ADDR.
    sel = 0;
    idx = 0; donecnt = 0;
    run(100, 1'b0, 1'b0, 10, -1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy",  64'(busy_a[0]),  64'd0);
    chk("mid_rst_valid", 64'(valid_a[0]), 64'd0);
    chk("mid_rst_addr",  64'(addr_a[0]),  64'd2048);
    chk("mid_rst_done",  64'(done_a[0]),  64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_a[0]) donecnt++;
    end
    chk("mid_rst_no_done", 64'(donecnt), 64'd0);
    chk("mid_rst_idle_valid", 64'(valid_a[0]), 64'd0);
    idx = 0; donecnt = 0;
    run(600, 1'b1, 1'b0, -1, -1);

    // Weight region.
    sel = 2;
    idx = 0; donecnt = 0;
    run(2200, 1'b1, 1'b0, -1, -1);
    chk("weight_total", 64'(idx), 64'd2048);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
